// File: rtl/uart_rx_pkg.sv
// Shared UART constants for the receiver, the programmer stage and a future uart_tx.
// Frame geometry defaults plus the baud-derived half-bit offset.
package uart_rx_pkg;

    localparam int DEF_UART_DATA_LENGTH = 8;
    localparam int DEF_CLKS_PER_BIT     = 16;

    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

    localparam int DEF_HALF_BIT = half_bit(DEF_CLKS_PER_BIT);

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous input pins.
// The reset value lets the output start at the pin's idle level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            meta <= RESET_VAL;
            q_o  <= RESET_VAL;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver for the CPU programming path.
// Emits one-cycle data/frame-error strobes; busy whenever a frame is in flight.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT     = DEF_CLKS_PER_BIT,
    parameter int UART_DATA_LENGTH = DEF_UART_DATA_LENGTH
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        rx_i,
    output logic [UART_DATA_LENGTH-1:0] data_o,
    output logic                        data_valid_strb_o,
    output logic                        frame_error_o,
    output logic                        busy_o
);

    localparam int H  = half_bit(CLKS_PER_BIT);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (UART_DATA_LENGTH > 1) ? $clog2(UART_DATA_LENGTH) : 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                      state, state_n;
    logic [CW-1:0]               cnt, cnt_n;
    logic [BW-1:0]               bit_cnt, bit_n;
    logic [UART_DATA_LENGTH-1:0] shift, shift_n;
    logic [UART_DATA_LENGTH-1:0] data_n;
    logic                        strb_n;
    logic                        ferr_n;
    logic                        rx_s;
    logic                        rx_prev;
    logic                        fall;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .d_i    (rx_i),
        .q_o    (rx_s)
    );

    // Edge-based start: a line held low cannot retrigger frames.
    assign fall   = rx_prev & ~rx_s;
    assign busy_o = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        data_n  = data_o;
        strb_n  = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (fall) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n = '0;
                    bit_n = '0;
                    state_n = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[UART_DATA_LENGTH-1:1]};
                    if (bit_cnt == BIT_LAST) begin
                        state_n = STOP;
                    end else begin
                        bit_n = bit_cnt + BW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (rx_s) begin
                        data_n = shift;
                        strb_n = 1'b1;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state             <= IDLE;
            cnt               <= '0;
            bit_cnt           <= '0;
            shift             <= '0;
            rx_prev           <= 1'b1;
            data_o            <= '0;
            data_valid_strb_o <= 1'b0;
            frame_error_o     <= 1'b0;
        end else begin
            state             <= state_n;
            cnt               <= cnt_n;
            bit_cnt           <= bit_n;
            shift             <= shift_n;
            rx_prev           <= rx_s;
            data_o            <= data_n;
            data_valid_strb_o <= strb_n;
            frame_error_o     <= ferr_n;
        end
    end

endmodule
